print_serializer: RTL and testbench
===================================

// Module: print_serializer
// PURPOSE
//  Sits between the core's print path and the UART output controller.
//  Accepts one print request of 1-4 bytes packed in a 32-bit word and emits
//  the bytes one at a time on the byte-wide print/data interface of the
//  output controller.
//  Honours the controller's FIFO-full stall and back-pressures the core
//  while a previous request is still being drained.
// PARAMETERS
//  BIG_ENDIAN  0   0: byte 0 = wdata[7:0] sent first; 1: wdata[31:24] first
//  CNT_W       32  width of the sent-byte counter
// PORTS
//  clk          in   1      clock
//  reset        in   1      synchronous, active-high reset
//  req          in   1      core print request; held high until accepted
//  wdata        in   32     word holding the bytes to print
//  len          in   2      number of bytes minus 1 (00=1 .. 11=4)
//  core_stall   out  1      high: req not accepted this cycle, core must hold
//  print        out  1      byte valid toward output controller
//  dout_core    out  8      byte toward output controller
//  out_stall    in   1      controller stall (its print & fifo full)
//  busy         out  1      request in progress (state != IDLE)
//  bytes_sent   out  CNT_W  total bytes consumed since reset, wraps
// BEHAVIOUR
//  Reset: state=IDLE, print=0, dout_core=0, busy=0, bytes_sent=0.
//  Reset mid-request discards the remaining bytes.
//  core_stall is combinational: req & ~accept.
//  States: IDLE, SEND.
//  Registers: shreg[31:0], remaining[1:0] (bytes left minus 1).
//  accept = req & (state==IDLE | last_take).
//  take = print & ~out_stall; a byte is consumed only on take.
//  last_take = take & (remaining==0).
//  IDLE:
//   - On req: accept and load shreg=wdata, remaining=len.
//   - Next state is SEND; the first byte is presented the following cycle,
//     so latency from req to first print is 1 cycle.
//  SEND:
//   - print=1; dout_core = shreg[7:0] (BIG_ENDIAN=0) or shreg[31:24] (=1).
//   - On take with remaining!=0: shift shreg by 8 toward the output byte,
//     remaining-=1.
//   - On last_take with req=1: load new request, stay in SEND. This gives
//     back-to-back bytes with no bubble.
//   - On last_take with req=0: go to IDLE; print=0 next cycle.
//   - out_stall=1: hold shreg, remaining, dout_core and print stable.
//  Registered outputs: print and dout_core, driven from state/shreg.
//  dout_core keeps its last value in IDLE.
//  bytes_sent increments by 1 on every take, modulo 2^CNT_W.
//  req while in SEND, not on last_take: core_stall=1, no state change.
//  Peak throughput is 1 byte/cycle.
//  A 4-byte request occupies SEND for >= 4 cycles.
//  len is sampled only on accept; later changes to len/wdata are ignored.
//  out_stall while print=0 is ignored.
// TESTING
//  1. req, wdata=0x44434241, len=3, out_stall=0 -> print high 4 cycles
//     starting 1 cycle after req, dout 41,42,43,44; bytes_sent=4; core_stall=0.
//  2. BIG_ENDIAN=1, same stimulus -> dout 44,43,42,41.
//  3. len=0 req 0x..5A, out_stall=1 for 3 cycles after print rises ->
//     dout holds 5A and print held high while stalled; 1 take; bytes_sent=1.
//  4. Second req (0x00000A0D, len=1) raised during the first 4-byte send ->
//     core_stall=1 until the last byte is taken; then 0D,0A follow with no
//     idle cycle; total 6 bytes.
//  5. reset asserted after 2 of 4 bytes -> next cycle print=0, busy=0,
//     bytes_sent=0; the next req starts from byte 0 of its new word.
//  6. CNT_W=4, send 17 single bytes -> bytes_sent wraps to 1.

Source files
------------

// File: rtl/print_serializer.sv
// Byte serializer between the core print path and the UART output controller.
// Accepts a 1-4 byte request packed in a 32-bit word and emits one byte per take.
module print_serializer #(
    parameter bit          BIG_ENDIAN = 1'b0,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [31:0]      wdata,
    input  logic [1:0]       len,
    output logic             core_stall,
    output logic             print,
    output logic [7:0]       dout_core,
    input  logic             out_stall,
    output logic             busy,
    output logic [CNT_W-1:0] bytes_sent
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state, state_n;
    logic [31:0] shreg, shreg_n, shifted;
    logic [1:0]  remaining, remaining_n;
    logic        print_n;
    logic [7:0]  dout_n;
    logic        take, last_take, accept;

    function automatic logic [7:0] head(input logic [31:0] w);
        return BIG_ENDIAN ? w[31:24] : w[7:0];
    endfunction

    assign take       = print & ~out_stall;
    assign last_take  = take & (remaining == 2'd0);
    assign accept     = req & ((state == IDLE) | last_take);
    assign core_stall = req & ~accept;
    assign busy       = (state != IDLE);
    assign shifted    = BIG_ENDIAN ? {shreg[23:0], 8'h00} : {8'h00, shreg[31:8]};

    // print/dout_core are registered, so they are computed from the next shreg
    // head; this keeps dout_core equal to the head byte throughout SEND.
    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        remaining_n = remaining;
        print_n     = print;
        dout_n      = dout_core;
        if (accept) begin
            state_n     = SEND;
            shreg_n     = wdata;
            remaining_n = len;
            print_n     = 1'b1;
            dout_n      = head(wdata);
        end else if (last_take) begin
            state_n = IDLE;
            print_n = 1'b0;
        end else if (take) begin
            shreg_n     = shifted;
            remaining_n = remaining - 2'd1;
            dout_n      = head(shifted);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            remaining  <= '0;
            print      <= 1'b0;
            dout_core  <= '0;
            bytes_sent <= '0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            remaining <= remaining_n;
            print     <= print_n;
            dout_core <= dout_n;
            if (take)
                bytes_sent <= bytes_sent + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_print_serializer.sv
// Bench for print_serializer: three instances (little-endian, big-endian,
// 4-bit counter) compared every cycle against a byte-queue reference model.
module tb_print_serializer;

    logic        clk = 1'b0;
    logic        reset, req, out_stall;
    logic [31:0] wdata;
    logic [1:0]  len;

    logic        cs_le, pr_le, bz_le;
    logic [7:0]  do_le;
    logic [31:0] bs_le;
    logic        cs_be, pr_be, bz_be;
    logic [7:0]  do_be;
    logic [31:0] bs_be;
    logic        cs_w4, pr_w4, bz_w4;
    logic [7:0]  do_w4;
    logic [3:0]  bs_w4;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    print_serializer #(.BIG_ENDIAN(1'b0), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata), .len(len),
        .core_stall(cs_le), .print(pr_le), .dout_core(do_le),
        .out_stall(out_stall), .busy(bz_le), .bytes_sent(bs_le));

    print_serializer #(.BIG_ENDIAN(1'b1), .CNT_W(32)) dut_be (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata), .len(len),
        .core_stall(cs_be), .print(pr_be), .dout_core(do_be),
        .out_stall(out_stall), .busy(bz_be), .bytes_sent(bs_be));

    print_serializer #(.BIG_ENDIAN(1'b0), .CNT_W(4)) dut_w4 (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata), .len(len),
        .core_stall(cs_w4), .print(pr_w4), .dout_core(do_w4),
        .out_stall(out_stall), .busy(bz_w4), .bytes_sent(bs_w4));

    // Reference model: pending bytes of the current request in send order.
    logic [7:0]  q_le[$];
    logic [7:0]  q_be[$];
    bit          active      = 1'b0;
    bit          model_valid = 1'b0;
    bit          accepted    = 1'b0;
    logic [31:0] cnt         = '0;
    logic [7:0]  last_le     = '0;
    logic [7:0]  last_be     = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic r, input logic [31:0] wd,
                        input logic [1:0] ln, input logic os);
        bit         tk;
        logic [7:0] e_le, e_be;
        bit         e_cs;
        @(negedge clk);
        reset = rst; req = r; wdata = wd; len = ln; out_stall = os;
        #1;
        if (model_valid) begin
            e_le = active ? q_le[0] : last_le;
            e_be = active ? q_be[0] : last_be;
            e_cs = r && !(!active || (!os && q_le.size() == 1));
            check("le_print",      32'(pr_le), 32'(active));
            check("le_dout",       32'(do_le), 32'(e_le));
            check("le_core_stall", 32'(cs_le), 32'(e_cs));
            check("le_busy",       32'(bz_le), 32'(active));
            check("le_bytes_sent", bs_le, cnt);
            check("be_print",      32'(pr_be), 32'(active));
            check("be_dout",       32'(do_be), 32'(e_be));
            check("be_bytes_sent", bs_be, cnt);
            check("w4_core_stall", 32'(cs_w4), 32'(e_cs));
            check("w4_bytes_sent", 32'(bs_w4), cnt % 16);
        end
        if (rst) begin
            q_le.delete(); q_be.delete();
            active = 1'b0; cnt = '0; last_le = '0; last_be = '0;
            accepted = 1'b0; model_valid = 1'b1;
        end else begin
            tk       = active && !os;
            accepted = r && (!active || (tk && q_le.size() == 1));
            if (tk) begin
                void'(q_le.pop_front());
                void'(q_be.pop_front());
                cnt++;
            end
            if (accepted) begin
                for (int i = 0; i <= int'(ln); i++) begin
                    q_le.push_back(wd[8*i +: 8]);
                    q_be.push_back(wd[8*(3-i) +: 8]);
                end
                active = 1'b1;
            end else if (tk && q_le.size() == 0) begin
                active = 1'b0;
            end
            if (active) begin
                last_le = q_le[0];
                last_be = q_be[0];
            end
        end
    endtask

    // Holds req with fixed data until the model accepts it (bounded).
    task automatic hold_req(input logic [31:0] wd, input logic [1:0] ln, input int stall_pct);
        int n = 0;
        accepted = 1'b0;
        while (!accepted && n < 40) begin
            step(1'b0, 1'b1, wd, ln, ($urandom_range(99) < stall_pct));
            n++;
        end
        if (!accepted) check("req_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, 2'($urandom), 1'b0);
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; wdata = '0; len = '0; out_stall = 1'b0;
        step(1'b1, 1'b0, 32'h0, 2'd0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 2'd0, 1'b0);

        // Four bytes, no stall; big-endian instance sees reverse order.
        step(1'b0, 1'b1, 32'h44434241, 2'd3, 1'b0);
        idle(6);

        // Single byte, stalled three cycles once print rises.
        step(1'b0, 1'b1, 32'hDEADBE5A, 2'd0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
        idle(3);

        // Second request arrives mid-send and chains without a bubble.
        step(1'b0, 1'b1, 32'h44434241, 2'd3, 1'b0);
        step(1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        hold_req(32'h00000A0D, 2'd1, 0);
        idle(4);

        // Reset after two of four bytes, then a fresh request.
        step(1'b0, 1'b1, 32'h44434241, 2'd3, 1'b0);
        step(1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 2'd0, 1'b0);
        step(1'b0, 1'b1, 32'h88776655, 2'd3, 1'b0);
        idle(6);

        // Seventeen single bytes wrap the 4-bit counter to 1.
        step(1'b1, 1'b0, 32'h0, 2'd0, 1'b0);
        for (int i = 0; i < 17; i++) hold_req($urandom, 2'd0, 0);
        idle(3);
        check("w4_wrap_17", 32'(bs_w4), 32'd1);

        // Randomized traffic with back-pressure and data changes while held.
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(2) == 0) hold_req($urandom, 2'($urandom), 35);
            else step(1'b0, 1'b0, $urandom, 2'($urandom), ($urandom_range(99) < 35));
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
